vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@56 Hz raster timing with blanked, registered colour.
// The optional frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
// The sync/blank terms are delayed by PIPE_DLY clocks (legal 0-4) so they line up
// with colour coming back from the renderer, then all pins share one output register.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 72,
   parameter int H_BP     = 128,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 22,
   parameter int PIPE_DLY = 1
) (
   input  logic       pixel_clk,
   input  logic       rst,
   output logic [9:0] h_coord,
   output logic [9:0] v_coord,
   output logic       frame_start,
   input  logic [3:0] red_in,
   input  logic [3:0] green_in,
   input  logic [3:0] blue_in,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic de0, hs0, vs0;
   logic de_d, hs_d, vs_d;
   logic h_wrap;

   assign h_wrap = (h_coord == H_LAST);

   // Raster counters: pixel counter every clock, line counter only on a line wrap.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         h_coord <= 10'd0;
         v_coord <= 10'd0;
      end else if (h_wrap) begin
         h_coord <= 10'd0;
         v_coord <= (v_coord == V_LAST) ? 10'd0 : v_coord + 10'd1;
      end else begin
         h_coord <= h_coord + 10'd1;
      end
   end

   // Frame pulse marks the (0,0) that follows a real wrap, never the reset restart.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= h_wrap && (v_coord == V_LAST);
      end
   end

   // Vertical sync is decoded purely from the line number, so it changes on line boundaries.
   assign de0 = (h_coord < H_VIS) && (v_coord < V_VIS);
   assign hs0 = (h_coord >= HS_FIRST) && (h_coord <= HS_LAST);
   assign vs0 = (v_coord >= VS_FIRST) && (v_coord <= VS_LAST);

   generate
      if (PIPE_DLY == 0) begin : g_no_pipe
         assign {de_d, hs_d, vs_d} = {de0, hs0, vs0};
      end else begin : g_pipe
         logic [2:0] stage [PIPE_DLY];

         // Shift the timing terms so they meet the renderer colour for the same pixel.
         always_ff @(posedge pixel_clk) begin
            if (rst) begin
               for (int i = 0; i < PIPE_DLY; i++) stage[i] <= 3'b000;
            end else begin
               stage[0] <= {de0, hs0, vs0};
               for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
            end
         end

         assign {de_d, hs_d, vs_d} = stage[PIPE_DLY-1];
      end
   endgenerate

   // Pin register: colour is forced to black outside active video.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         vga_hs <= 1'b0;
         vga_vs <= 1'b0;
         vga_r  <= 4'h0;
         vga_g  <= 4'h0;
         vga_b  <= 4'h0;
      end else begin
         vga_hs <= hs_d;
         vga_vs <= vs_d;
         vga_r  <= de_d ? red_in   : 4'h0;
         vga_g  <= de_d ? green_in : 4'h0;
         vga_b  <= de_d ? blue_in  : 4'h0;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   // Frame counter advances once per frame pulse and wraps naturally at 16 bits.
   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         frame_cnt <= 16'd0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with default horizontal
// timing and a shortened vertical frame so several whole frames fit in the run.
module tb_vga_timing_gen;

   localparam int HT  = 1024;
   localparam int VA  = 4;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam int VT  = VA + VFP + VS + VBP;

   logic       pixel_clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] red_in = 4'h0, green_in = 4'h0, blue_in = 4'h0;
   logic [9:0] h_coord, v_coord;
   logic       frame_start;
   logic [3:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   vga_timing_gen #(
      .H_ACTIVE(800), .H_FP(24), .H_SYNC(72), .H_BP(128),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .PIPE_DLY(1)
   ) dut (
      .pixel_clk(pixel_clk), .rst(rst),
      .h_coord(h_coord), .v_coord(v_coord), .frame_start(frame_start),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   // Free-running pixel clock.
   always #5 pixel_clk = ~pixel_clk;

   int assert_cnt = 0;
   int fail_cnt = 0;

   logic [9:0]  mh = 10'd0;
   logic [9:0]  mv = 10'd0;
   logic        mfs = 1'b0;
   logic [15:0] mfc = 16'd0;
   logic [13:0] sb [$];
   logic [11:0] next_colour = 12'h000;
   logic        white = 1'b0;
   logic        prev_hs = 1'b0, prev_vs = 1'b0;
   int          hs_w = 0, vs_w = 0, line_cnt = 0, fs_cnt = 0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] col_of(input logic [9:0] h, input logic [9:0] v);
      if (white) return 12'hFFF;
      return {h[3:0] ^ 4'h5, v[3:0] ^ 4'hA, h[7:4] ^ 4'h3};
   endfunction

   function automatic logic [13:0] expect_pins(input logic [9:0] h, input logic [9:0] v,
                                               input logic [11:0] col);
      logic de, hs, vs;
      de = (h < 10'd800) && (v < 10'(VA));
      hs = (h >= 10'd824) && (h <= 10'd895);
      vs = (v >= 10'(VA + VFP)) && (v <= 10'(VA + VFP + VS - 1));
      return {hs, vs, de ? col : 12'h000};
   endfunction

   // One clock: compare this cycle against the model, then drive and predict the next.
   task automatic apply_stimulus(input logic r);
      logic [13:0] exp_pins;
      logic [11:0] col;
      @(negedge pixel_clk);
      check_output("h_coord", 32'(h_coord), 32'(mh));
      check_output("v_coord", 32'(v_coord), 32'(mv));
      check_output("frame_start", 32'(frame_start), 32'(mfs));
      exp_pins = sb.pop_front();
      check_output("pins", 32'({vga_hs, vga_vs, vga_r, vga_g, vga_b}), 32'(exp_pins));
`ifdef VGA_TIMING_FRAME_CNT_EN
      check_output("frame_cnt", 32'(frame_cnt), 32'(mfc));
`endif
      fs_cnt += int'(frame_start);
      if (vga_hs && !prev_hs) begin
         check_output("hs_rise_h", 32'(mh), 32'd826);
         hs_w = 0;
      end
      if (vga_hs) hs_w++;
      if (!vga_hs && prev_hs) check_output("hs_width", 32'(hs_w), 32'd72);
      prev_hs = vga_hs;
      if (vga_vs && !prev_vs) begin
         check_output("vs_rise_pos", 32'({mv, mh}), 32'({10'(VA + VFP), 10'd2}));
         vs_w = 0;
      end
      if (vga_vs) vs_w++;
      if (!vga_vs && prev_vs) check_output("vs_width", 32'(vs_w), 32'd2048);
      prev_vs = vga_vs;
      if (white) begin
         if ({vga_r, vga_g, vga_b} == 12'hFFF) line_cnt++;
         if (mh == 10'd1023) begin
            check_output("white_line_px", 32'(line_cnt), (mv < 10'(VA)) ? 32'd800 : 32'd0);
            line_cnt = 0;
         end
      end

      rst = r;
      {red_in, green_in, blue_in} = next_colour;
      col = col_of(mh, mv);
      if (r) sb[0] = 14'h0;
      sb.push_back(r ? 14'h0 : expect_pins(mh, mv, col));
      next_colour = col;

      if (r) begin
         mh = 10'd0; mv = 10'd0; mfs = 1'b0; mfc = 16'd0;
      end else begin
         mfc = mfc + 16'(mfs);
         mfs = (mh == 10'(HT - 1)) && (mv == 10'(VT - 1));
         if (mh == 10'(HT - 1)) begin
            mh = 10'd0;
            mv = (mv == 10'(VT - 1)) ? 10'd0 : mv + 10'd1;
         end else begin
            mh = mh + 10'd1;
         end
      end
   endtask

   // Run until the model is about to present (h, v), with a bounded cycle budget.
   task automatic run_until(input logic [9:0] h, input logic [9:0] v);
      int n;
      n = 0;
      while (!(mh == h && mv == v) && n < 2 * HT * VT) begin
         apply_stimulus(1'b0);
         n++;
      end
      if (n >= 2 * HT * VT) check_output("run_until_timeout", 32'd1, 32'd0);
   endtask

   // Hard stop in case something outside the bounded loops stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence of test phases.
   initial begin
      sb.push_back(14'h0);
      sb.push_back(14'h0);

      $display("[TB] reset phase");
      repeat (4) apply_stimulus(1'b1);

      $display("[TB] full frame with patterned colour");
      fs_cnt = 0;
      repeat (HT * VT + 1) apply_stimulus(1'b0);
      check_output("frame_start_count", 32'(fs_cnt), 32'd1);

      $display("[TB] constant white frame");
      run_until(10'd0, 10'd0);
      white = 1'b1;
      line_cnt = 0;
      repeat (HT * VT) apply_stimulus(1'b0);
      white = 1'b0;

      $display("[TB] mid-frame reset");
      run_until(10'd500, 10'd3);
      fs_cnt = 0;
      repeat (3) apply_stimulus(1'b1);
      repeat (2000) apply_stimulus(1'b0);
      check_output("fs_after_release", 32'(fs_cnt), 32'd0);

`ifdef VGA_TIMING_FRAME_CNT_EN
      $display("[TB] frame counter");
      repeat (2) apply_stimulus(1'b1);
      repeat (3 * HT * VT + 2) apply_stimulus(1'b0);
      check_output("frame_cnt_3", 32'(frame_cnt), 32'd3);
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      mfc = 16'hFFFF;
      run_until(10'd2, 10'd0);
      check_output("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
